// File: rtl/multi_clock_divider.sv
// multi_clock_divider: per-channel programmable clock divider with tick strobes and glitch-free divisor reload
//   Clk_In/Reset : system clock, synchronous active-high reset
//   Enable       : per-channel run enable (1-cycle latency)
//   Sync         : restart every channel at phase 0 and apply pending divisors
//   Load_*       : valid/ready divisor load into a channel's shadow register
//   Clk_Out/Tick : registered divided clocks and period-start strobes
module multi_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                Clk_In,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Enable,
  input  logic                Sync,
  input  logic                Load_Valid,
  input  logic [CW-1:0]       Load_Chan,
  input  logic [WIDTH-1:0]    Load_Div,
  output logic                Load_Ready,
  output logic [CHANNELS-1:0] Clk_Out,
  output logic [CHANNELS-1:0] Tick
);
  logic [CHANNELS-1:0] pend;
  logic [WIDTH-1:0] ld_div;
  assign ld_div = (Load_Div < WIDTH'(2)) ? WIDTH'(2) : Load_Div;
  // out-of-range channels keep the default of 1 so their loads are swallowed
  always_comb begin
    Load_Ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (Load_Chan == CW'(i)) Load_Ready = Reset | ~pend[i];
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] d_q, d_d, s_q, s_d, cnt_q, cnt_d;
    logic pend_q, pend_d, run_q, run_d, clk_q, clk_d, tick_q, tick_d;
    logic ld, wrap, apply;
    always_comb begin
      ld = Load_Valid & Load_Ready & (Load_Chan == CW'(g));
      wrap = run_q & Enable[g] & (cnt_q == d_q - WIDTH'(1));
      apply = Sync | ~Enable[g] | wrap;
      run_d = Enable[g];
      // routing the load through s_d lets a load on an apply edge take effect at once
      s_d = ld ? ld_div : s_q;
      d_d = apply ? s_d : d_q;
      pend_d = ~apply & (ld | pend_q);
      cnt_d = (apply | ~run_q) ? '0 : cnt_q + WIDTH'(1);
      // high for ceil(D/2) cycles; computed without an extra bit so D = 2^WIDTH-1 is safe
      clk_d = run_d & (cnt_d < (d_d >> 1) + WIDTH'(d_d[0]));
      tick_d = run_d & (cnt_d == '0);
    end
    always_ff @(posedge Clk_In) begin
      if (Reset) begin
        d_q <= WIDTH'(DEFAULT_DIV);
        s_q <= WIDTH'(DEFAULT_DIV);
        pend_q <= 1'b0;
        cnt_q <= '0;
        run_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        d_q <= d_d;
        s_q <= s_d;
        pend_q <= pend_d;
        cnt_q <= cnt_d;
        run_q <= run_d;
        clk_q <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign pend[g] = pend_q;
    assign Clk_Out[g] = clk_q;
    assign Tick[g] = tick_q;
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: directed vector bench for multi_clock_divider
module tb_multi_clock_divider;
  localparam int CH = 5;
  logic clk, rst, sync, lv, rdy;
  logic [CH-1:0] en, co, tk;
  logic [2:0] lc;
  logic [15:0] ld;
  int total = 0, passed = 0;

  multi_clock_divider #(.CHANNELS(CH), .WIDTH(16), .DEFAULT_DIV(2)) dut (
    .Clk_In(clk), .Reset(rst), .Enable(en), .Sync(sync), .Load_Valid(lv),
    .Load_Chan(lc), .Load_Div(ld), .Load_Ready(rdy), .Clk_Out(co), .Tick(tk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] en;
    logic lv;
    logic [2:0] lc;
    logic [15:0] ld;
    logic rdy;
    logic [CH-1:0] clk;
    logic [CH-1:0] tick;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [CH-1:0] e, input logic v, input logic [2:0] c, input logic [15:0] d);
    en = e; lv = v; lc = c; ld = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [CH-1:0] c, input logic [CH-1:0] t);
    chk({name, "_clk"}, 32'(co), 32'(c));
    chk({name, "_tick"}, 32'(tk), 32'(t));
  endtask

  task automatic chk_rdy(input string name, input logic e);
    #1;
    chk({name, "_rdy"}, 32'(rdy), 32'(e));
  endtask

  initial begin
    logic [15:0] divs[4];
    logic [CH-1:0] ec, et;
    logic [CH-1:0] s3c[5], s3t[5];
    divs = '{16'd3, 16'd4, 16'd5, 16'd7};
    tbl[0]  = '{5'h01, 1'b0, 3'd0, 16'd0, 1'b1, 5'h01, 5'h01};
    tbl[1]  = '{5'h01, 1'b0, 3'd0, 16'd0, 1'b1, 5'h00, 5'h00};
    tbl[2]  = '{5'h01, 1'b0, 3'd0, 16'd0, 1'b1, 5'h01, 5'h01};
    tbl[3]  = '{5'h01, 1'b0, 3'd0, 16'd0, 1'b1, 5'h00, 5'h00};
    tbl[4]  = '{5'h00, 1'b1, 3'd1, 16'd5, 1'b1, 5'h00, 5'h00};
    tbl[5]  = '{5'h02, 1'b0, 3'd1, 16'd0, 1'b1, 5'h02, 5'h02};
    tbl[6]  = '{5'h02, 1'b0, 3'd1, 16'd0, 1'b1, 5'h02, 5'h00};
    tbl[7]  = '{5'h02, 1'b0, 3'd1, 16'd0, 1'b1, 5'h02, 5'h00};
    tbl[8]  = '{5'h02, 1'b0, 3'd1, 16'd0, 1'b1, 5'h00, 5'h00};
    tbl[9]  = '{5'h02, 1'b0, 3'd1, 16'd0, 1'b1, 5'h00, 5'h00};
    tbl[10] = '{5'h02, 1'b0, 3'd1, 16'd0, 1'b1, 5'h02, 5'h02};

    rst = 1'b1; sync = 1'b0;
    drive(5'h00, 1'b0, 3'd0, 16'd0);
    #2;
    chk("reset_held", 32'(rdy), 32'd1);
    step;
    step;
    chk_out("reset", 5'h00, 5'h00);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].en, tbl[i].lv, tbl[i].lc, tbl[i].ld);
      chk_rdy($sformatf("tbl%0d", i), tbl[i].rdy);
      step;
      chk_out($sformatf("tbl%0d", i), tbl[i].clk, tbl[i].tick);
    end

    // run-time reload with a stalled second load
    drive(5'h00, 1'b1, 3'd0, 16'd6);
    step;
    drive(5'h01, 1'b0, 3'd0, 16'd0);
    step; chk_out("d6_p0", 5'h01, 5'h01);
    step; chk_out("d6_p1", 5'h01, 5'h00);
    step; chk_out("d6_p2", 5'h01, 5'h00);
    drive(5'h01, 1'b1, 3'd0, 16'd3);
    chk_rdy("ld3", 1'b1);
    step; chk_out("d6_p3", 5'h00, 5'h00);
    drive(5'h01, 1'b1, 3'd0, 16'd4);
    chk_rdy("ld4_a", 1'b0);
    step; chk_out("d6_p4", 5'h00, 5'h00);
    chk_rdy("ld4_b", 1'b0);
    step; chk_out("d6_p5", 5'h00, 5'h00);
    chk_rdy("ld4_c", 1'b0);
    step; chk_out("d3_p0", 5'h01, 5'h01);
    chk_rdy("ld4_d", 1'b1);
    step; chk_out("d3_p1", 5'h01, 5'h00);
    drive(5'h01, 1'b0, 3'd0, 16'd0);
    chk_rdy("ld4_pend", 1'b0);
    step; chk_out("d3_p2", 5'h00, 5'h00);
    s3c = '{5'h01, 5'h01, 5'h00, 5'h00, 5'h01};
    s3t = '{5'h01, 5'h00, 5'h00, 5'h00, 5'h01};
    for (int i = 0; i < 5; i++) begin
      step;
      chk_out($sformatf("d4_%0d", i), s3c[i], s3t[i]);
    end

    // load landing on a wrap edge bypasses the shadow
    drive(5'h00, 1'b1, 3'd2, 16'd4);
    step;
    drive(5'h04, 1'b0, 3'd2, 16'd0);
    step; chk_out("c2_p0", 5'h04, 5'h04);
    step; chk_out("c2_p1", 5'h04, 5'h00);
    step; chk_out("c2_p2", 5'h00, 5'h00);
    step; chk_out("c2_p3", 5'h00, 5'h00);
    drive(5'h04, 1'b1, 3'd2, 16'd2);
    chk_rdy("c2_wrapld", 1'b1);
    step; chk_out("c2_new0", 5'h04, 5'h04);
    drive(5'h04, 1'b0, 3'd2, 16'd0);
    chk_rdy("c2_nopend", 1'b1);
    step; chk_out("c2_new1", 5'h00, 5'h00);
    step; chk_out("c2_new2", 5'h04, 5'h04);

    // sync alignment across D=3,4,5,7
    for (int i = 0; i < 4; i++) begin
      drive(5'h00, 1'b1, 3'(i), divs[i]);
      step;
    end
    drive(5'h0f, 1'b0, 3'd0, 16'd0);
    for (int i = 0; i < 5; i++) step;
    sync = 1'b1;
    step; chk_out("sync", 5'h0f, 5'h0f);
    sync = 1'b0;
    for (int k = 1; k < 15; k++) begin
      step;
      ec = '0; et = '0;
      for (int i = 0; i < 4; i++) begin
        ec[i] = (k % int'(divs[i])) < (int'(divs[i]) + 1) / 2;
        et[i] = (k % int'(divs[i])) == 0;
      end
      chk_out($sformatf("align%0d", k), ec, et);
    end
    rst = 1'b1; sync = 1'b1;
    step; chk_out("sync_rst", 5'h00, 5'h00);
    rst = 1'b0; sync = 1'b0;

    // divisor coercion of 0 and 1
    drive(5'h00, 1'b1, 3'd0, 16'd5); step;
    drive(5'h00, 1'b1, 3'd1, 16'd5); step;
    drive(5'h00, 1'b1, 3'd0, 16'd0); step;
    drive(5'h00, 1'b1, 3'd1, 16'd1); step;
    drive(5'h03, 1'b0, 3'd0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk_out($sformatf("coerce%0d", i), i % 2 ? 5'h00 : 5'h03, i % 2 ? 5'h00 : 5'h03);
    end

    // out-of-range channel loads are accepted and dropped
    drive(5'h00, 1'b1, 3'd5, 16'd9);
    chk_rdy("oob5", 1'b1);
    step;
    drive(5'h00, 1'b1, 3'd7, 16'd9);
    chk_rdy("oob7", 1'b1);
    step;
    drive(5'h1f, 1'b0, 3'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk_out($sformatf("oob_run%0d", i), i % 2 ? 5'h00 : 5'h1f, i % 2 ? 5'h00 : 5'h1f);
    end

    // reset discards a pending load
    drive(5'h00, 1'b0, 3'd0, 16'd0); step;
    drive(5'h01, 1'b0, 3'd0, 16'd0);
    step; chk_out("pr_p0", 5'h01, 5'h01);
    drive(5'h01, 1'b1, 3'd0, 16'd7);
    chk_rdy("pr_ld", 1'b1);
    step; chk_out("pr_p1", 5'h00, 5'h00);
    drive(5'h01, 1'b0, 3'd0, 16'd0);
    chk_rdy("pr_pend", 1'b0);
    rst = 1'b1;
    step; chk_out("pr_rst", 5'h00, 5'h00);
    chk_rdy("pr_rst_held", 1'b1);
    rst = 1'b0;
    chk_rdy("pr_cleared", 1'b1);
    step; chk_out("pr_d0", 5'h01, 5'h01);
    step; chk_out("pr_d1", 5'h00, 5'h00);
    step; chk_out("pr_d2", 5'h01, 5'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
